round_pack: RTL and testbench
=============================

ROUND_PACK -- requirements
Module: round_pack

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning packed result width.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, meaning exponent field width.
REQ-003 SHALL have parameter SIG_WIDTH, default 23, meaning stored fraction width.
REQ-004 SHALL have parameter IN_SIG_WIDTH, default 48, meaning raw significand width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. All state is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: input beat offered.
REQ-008 SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid & in_ready.
REQ-009 SHALL have port in_sign, input, 1 bit: result sign.
REQ-010 SHALL have port in_exp, input, EXP_WIDTH+2 bits: signed two's-complement biased exponent.
REQ-011 SHALL have port in_sig, input, IN_SIG_WIDTH bits: raw significand. Binary point sits after bit IN_SIG_WIDTH-2.
REQ-012 SHALL have port in_is_nan, input, 1 bit: special-case flag.
REQ-013 SHALL have port in_is_inf, input, 1 bit: special-case flag.
REQ-014 SHALL have port in_is_zero, input, 1 bit: special-case flag.
REQ-015 SHALL have port out_valid, output, 1 bit: result beat offered.
REQ-016 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-017 SHALL have port Z, output, WIDTH bits: packed IEEE result {sign, exp, fraction}.
REQ-018 SHALL have port overflow, output, 1 bit: status flag, qualified by out_valid.
REQ-019 SHALL have port underflow, output, 1 bit: status flag, qualified by out_valid.
REQ-020 SHALL have port inexact, output, 1 bit: status flag, qualified by out_valid.

Function
REQ-021 SHALL be a 2-stage pipeline with valid/ready at each stage.
- S1: leading-zero count, normalize.
- S2: round, pack.
- Latency from accept to out_valid is exactly 2 cycles when unstalled.
REQ-022 SHALL advance stage k when it is empty or its successor advances.
- in_ready = !s1_valid | s1_advance.
- Full throughput is 1 beat/cycle.
REQ-023 SHALL hold Z and the flags stable while out_valid & !out_ready.
REQ-024 SHALL deliver beats in order, with no loss or duplication under any out_ready pattern.
REQ-025 S1 SHALL normalize as follows:
- Leading one at bit IN_SIG_WIDTH-1: shift right 1 into sticky, exp+1.
- Leading one below that: shift left by (lzc-1), exp-(lzc-1).
REQ-026 S1 SHALL handle tiny results as follows:
- Normalized exp <= 0: shift right by (1-exp), saturating at IN_SIG_WIDTH, all lost bits ORed into sticky.
- Packed exponent field is then 0.
REQ-027 S2 SHALL round to nearest, ties to even, using guard, round and sticky below the SIG_WIDTH fraction bits.
REQ-028 Rounding carry-out SHALL increment the exponent. A subnormal rounding up to 1.0x2^-126 SHALL pack as exponent field 1.
REQ-029 On overflow (final exponent >= 2^EXP_WIDTH-1), S2 SHALL output signed infinity with overflow=1 and inexact=1.
REQ-030 Flag definitions:
- inexact=1 iff any of guard, round or sticky is nonzero.
- underflow=1 iff the result is tiny before rounding and inexact.
REQ-031 Special-case priority SHALL be nan > inf > zero > normal:
- NaN: Z=0x7FC00000, sign ignored.
- Inf: {in_sign, all-ones exp, 0}.
- Zero: {in_sign, 0}.
- Special cases SHALL report all flags 0.
REQ-032 in_sig==0 with no flag set SHALL be treated as zero.
REQ-033 in_exp outside the representable range SHALL saturate through the overflow/tiny paths and never wrap.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL reset:
- s1_valid=0, s2_valid=0, out_valid=0.
- Z=0, overflow=0, underflow=0, inexact=0.
- in_ready=1 from the following cycle.
REQ-035 Reset mid-operation SHALL discard all in-flight beats. No beat accepted before reset SHALL appear after it.

Verification
REQ-036 SHALL cover: in_exp=127, in_sig=1<<46, sign 0, out_ready=1 -> Z=0x3F800000 two cycles after accept, all flags 0.
REQ-037 SHALL cover: in_exp=127, in_sig=(1<<46)|(1<<23)|(1<<22) (odd LSB, exact tie) -> Z=0x3F800002, inexact=1.
REQ-038 SHALL cover: in_exp=254, in_sig all ones -> Z=0x7F800000, overflow=1, inexact=1.
REQ-039 SHALL cover: in_exp=1, in_sig=1<<45 -> Z=0x00400000, underflow=0, inexact=0.
REQ-040 SHALL cover: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted, then all 4 results delivered in order.
REQ-041 SHALL cover: rst asserted with 2 beats in flight -> out_valid=0 next cycle, and neither beat is ever emitted.

Source files
------------

// File: rtl/round_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : round_pack
// Purpose  : Two-stage pipelined IEEE-754 round-and-pack unit. Takes a raw
//            sign / biased exponent / wide significand with special-case
//            flags and produces a packed floating-point word rounded to
//            nearest-even, together with overflow/underflow/inexact status.
//              S1: leading-zero count, normalize, denormalize tiny values
//              S2: round (guard/round/sticky), exponent adjust, pack
// Ports    : clk, rst                 clock, synchronous active-high reset
//            in_valid/in_ready        input handshake
//            in_sign, in_exp, in_sig  raw operand (in_exp is signed, the
//                                     binary point of in_sig is below bit
//                                     IN_SIG_WIDTH-2)
//            in_is_nan/inf/zero       special-case flags
//            out_valid/out_ready      output handshake
//            Z                        packed {sign, exponent, fraction}
//            overflow, underflow,
//            inexact                  status, qualified by out_valid
// Revision : 1.0  initial release
// ============================================================================
module round_pack #(
    parameter int WIDTH        = 32,
    parameter int EXP_WIDTH    = 8,
    parameter int SIG_WIDTH    = 23,
    parameter int IN_SIG_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_WIDTH+1:0]    in_exp,
    input  logic [IN_SIG_WIDTH-1:0] in_sig,
    input  logic                    in_is_nan,
    input  logic                    in_is_inf,
    input  logic                    in_is_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        Z,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);

    // Internal exponent is wide enough that normalization by the full
    // significand width can never wrap, whatever in_exp holds.
    localparam int EW  = EXP_WIDTH + 4;
    localparam int LZW = $clog2(IN_SIG_WIDTH + 1);
    localparam int NW  = IN_SIG_WIDTH - 1;      // normalized significand width
    localparam int H   = NW - 1;                // hidden-bit position
    localparam int GB  = H - SIG_WIDTH - 1;     // guard bit
    localparam int RB  = GB - 1;                // round bit

    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_WIDTH) - 1);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_ready;

    assign s2_ready = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;

    // ------------------------------------------------------------------
    // S1: leading-zero count and normalization
    // ------------------------------------------------------------------
    logic [LZW-1:0]         lzc;
    logic [LZW-1:0]         lzc_m1;
    logic signed [EW-1:0]   exp_ext;
    logic signed [EW-1:0]   exp_norm;
    logic [NW-1:0]          sig_norm;
    logic                   sticky_norm;
    logic                   tiny;
    logic [EW-1:0]          den_amt_raw;
    logic [EW-1:0]          den_amt;
    logic [NW-1:0]          lost_mask;

    logic [NW-1:0]          s1_sig_d;
    logic signed [EW-1:0]   s1_exp_d;
    logic                   s1_sticky_d;
    logic                   s1_tiny_d;
    logic [1:0]             s1_cls_d;

    always_comb begin : s1_lzc
        lzc = LZW'(IN_SIG_WIDTH);
        for (int i = 0; i < IN_SIG_WIDTH; i++) begin
            if (in_sig[i]) begin
                lzc = LZW'(IN_SIG_WIDTH - 1 - i);
            end
        end
    end

    always_comb begin : s1_norm
        lzc_m1      = lzc - LZW'(1);
        exp_ext     = {{(EW-EXP_WIDTH-2){in_exp[EXP_WIDTH+1]}}, in_exp};
        sig_norm    = '0;
        sticky_norm = 1'b0;
        exp_norm    = exp_ext;

        if (in_sig[IN_SIG_WIDTH-1]) begin
            // One integer bit too many: drop the LSB into sticky.
            sig_norm    = in_sig[IN_SIG_WIDTH-1:1];
            sticky_norm = in_sig[0];
            exp_norm    = exp_ext + EW'(1);
        end else begin
            // Top bit is zero here, so the narrower slice loses nothing.
            sig_norm = in_sig[NW-1:0] << lzc_m1;
            exp_norm = exp_ext - {{(EW-LZW){1'b0}}, lzc_m1};
        end

        // Tiny results are shifted down to the minimum-exponent scale;
        // everything shifted out is folded into sticky.
        tiny        = exp_norm[EW-1] | (exp_norm == '0);
        den_amt_raw = EW'(1) - exp_norm;
        den_amt     = '0;
        if (tiny) begin
            den_amt = (den_amt_raw >= EW'(IN_SIG_WIDTH)) ? EW'(IN_SIG_WIDTH)
                                                        : den_amt_raw;
        end
        lost_mask   = ~({NW{1'b1}} << den_amt);

        s1_sig_d    = sig_norm >> den_amt;
        s1_sticky_d = sticky_norm | (|(sig_norm & lost_mask));
        s1_exp_d    = exp_norm;
        s1_tiny_d   = tiny;

        if (in_is_nan) begin
            s1_cls_d = CLS_NAN;
        end else if (in_is_inf) begin
            s1_cls_d = CLS_INF;
        end else if (in_is_zero || (in_sig == '0)) begin
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_cls_d = CLS_NORM;
        end
    end

    logic [NW-1:0]          s1_sig_q;
    logic signed [EW-1:0]   s1_exp_q;
    logic                   s1_sticky_q;
    logic                   s1_tiny_q;
    logic [1:0]             s1_cls_q;
    logic                   s1_sign_q;

    // ------------------------------------------------------------------
    // S2: round to nearest even and pack
    // ------------------------------------------------------------------
    logic [SIG_WIDTH:0]     mant;
    logic                   guard_b;
    logic                   round_b;
    logic                   sticky_b;
    logic                   inc;
    logic [SIG_WIDTH+1:0]   sum;
    logic signed [EW-1:0]   e_base;
    logic signed [EW-1:0]   e_fin;
    logic [SIG_WIDTH-1:0]   frac;
    logic                   lost;

    logic [WIDTH-1:0]       z_d;
    logic                   ovf_d;
    logic                   unf_d;
    logic                   inx_d;

    always_comb begin : s2_round
        mant     = s1_sig_q[H -: SIG_WIDTH+1];
        guard_b  = s1_sig_q[GB];
        round_b  = s1_sig_q[RB];
        sticky_b = (|s1_sig_q[RB-1:0]) | s1_sticky_q;
        lost     = guard_b | round_b | sticky_b;
        inc      = guard_b & (round_b | sticky_b | mant[0]);
        sum      = {1'b0, mant} + {{(SIG_WIDTH+1){1'b0}}, inc};
        e_base   = s1_tiny_q ? '0 : s1_exp_q;

        if (sum[SIG_WIDTH+1]) begin
            // Mantissa rounded up to 2.0: renormalize.
            e_fin = e_base + EW'(1);
            frac  = sum[SIG_WIDTH:1];
        end else if (s1_tiny_q && sum[SIG_WIDTH]) begin
            // Subnormal rounded up into the smallest normal.
            e_fin = EW'(1);
            frac  = sum[SIG_WIDTH-1:0];
        end else begin
            e_fin = e_base;
            frac  = sum[SIG_WIDTH-1:0];
        end

        z_d   = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;

        case (s1_cls_q)
            CLS_NAN: begin
                z_d[WIDTH-2 -: EXP_WIDTH] = '1;
                z_d[SIG_WIDTH-1]          = 1'b1;
            end
            CLS_INF: begin
                z_d[WIDTH-1]              = s1_sign_q;
                z_d[WIDTH-2 -: EXP_WIDTH] = '1;
            end
            CLS_ZERO: begin
                z_d[WIDTH-1] = s1_sign_q;
            end
            default: begin
                if (e_fin >= EXP_MAX) begin
                    z_d[WIDTH-1]              = s1_sign_q;
                    z_d[WIDTH-2 -: EXP_WIDTH] = '1;
                    ovf_d                     = 1'b1;
                    inx_d                     = 1'b1;
                end else begin
                    z_d   = {s1_sign_q, e_fin[EXP_WIDTH-1:0], frac};
                    inx_d = lost;
                    unf_d = s1_tiny_q & lost;
                end
            end
        endcase
    end

    logic [WIDTH-1:0] z_q;
    logic             ovf_q;
    logic             unf_q;
    logic             inx_q;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sig_q    <= '0;
            s1_exp_q    <= '0;
            s1_sticky_q <= 1'b0;
            s1_tiny_q   <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_sign_q   <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sig_q    <= s1_sig_d;
                    s1_exp_q    <= s1_exp_d;
                    s1_sticky_q <= s1_sticky_d;
                    s1_tiny_q   <= s1_tiny_d;
                    s1_cls_q    <= s1_cls_d;
                    s1_sign_q   <= in_sign;
                end
            end
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    z_q   <= z_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                    inx_q <= inx_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_round_pack.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_round_pack
// Purpose  : Self-checking bench for round_pack: directed corner cases,
//            back-pressure, reset flush and random traffic compared against
//            an arithmetic rounding model through a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_sig = '0;
    logic        in_is_nan = 1'b0;
    logic        in_is_inf = 1'b0;
    logic        in_is_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Z;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Z          (Z),
        .overflow   (overflow),
        .underflow  (underflow),
        .inexact    (inexact)
    );

    always #5 clk = ~clk;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          n_deliv   = 0;
    logic [34:0] exp_q[$];
    bit          stall_prev = 0;
    logic [34:0] held;
    logic        last_acc, last_ir, last_ov;
    logic [34:0] last_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Result as a real number: sig * 2^(exp - 127 - 46). Quantize it to the
    // format's spacing at its binade (floored at the subnormal spacing).
    function automatic logic [34:0] model(input logic s, input logic [9:0] e,
                                          input logic [47:0] sig, input logic [2:0] fl);
        int ei, p, eb, qe, d, fieldv;
        longint unsigned sv, q, rem, half;
        bit inx, tiny;
        if (fl[2]) return {3'b000, 32'h7FC00000};
        if (fl[1]) return {3'b000, s, 8'hFF, 23'd0};
        if (fl[0] || sig == 48'd0) return {3'b000, s, 31'd0};
        ei = int'($signed(e));
        p  = 0;
        for (int i = 0; i < 48; i++) if (sig[i]) p = i;
        eb   = ei + p - 46;
        tiny = (eb <= 0);
        qe   = tiny ? 1 : eb;
        d    = qe - 23 - ei + 46;
        sv   = 64'(sig);
        if (d <= 0) begin
            q   = sv << (-d);
            inx = 0;
        end else begin
            if (d > 63) d = 63;
            q    = sv >> d;
            rem  = sv & ((64'd1 << d) - 64'd1);
            half = 64'd1 << (d - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q >= (64'd1 << 24)) begin
            q = q >> 1;
            qe++;
        end
        fieldv = (q >= (64'd1 << 23)) ? qe : 0;
        if (fieldv >= 255) return {3'b101, s, 8'hFF, 23'd0};
        return {1'b0, tiny & inx, inx, s, 8'(fieldv), q[22:0]};
    endfunction

    // One clock cycle: drive at the falling edge, observe 1 ns later,
    // score what the coming rising edge will transfer.
    task automatic step(input logic v, input logic s, input logic [9:0] e,
                        input logic [47:0] sg, input logic [2:0] fl, input logic ordy);
        logic [34:0] cur, expv;
        @(negedge clk);
        in_valid = v; in_sign = s; in_exp = e; in_sig = sg;
        {in_is_nan, in_is_inf, in_is_zero} = fl;
        out_ready = ordy;
        #1;
        cur     = {overflow, underflow, inexact, Z};
        last_ir = in_ready;
        last_ov = out_valid;
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(cur), 64'(held));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'(out_valid), 64'd0);
            end else begin
                expv = exp_q.pop_front();
                chk("result", 64'(cur), 64'(expv));
                n_deliv++;
                last_out = cur;
            end
        end
        last_acc = in_valid & in_ready;
        if (last_acc) exp_q.push_back(model(s, e, sg, fl));
        stall_prev = out_valid & ~out_ready;
        held       = cur;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 10'd0, 48'd0, 3'b000, ordy);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        stall_prev = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({overflow, underflow, inexact, Z}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic directed(input string tag, input logic s, input logic [9:0] e,
                            input logic [47:0] sg, input logic [2:0] fl, input logic [34:0] want);
        step(1'b1, s, e, sg, fl, 1'b1);
        chk({tag, "_acc"}, 64'(last_acc), 64'd1);
        idle(1'b1);
        chk({tag, "_lat1"}, 64'(last_ov), 64'd0);
        idle(1'b1);
        chk({tag, "_lat2"}, 64'(last_ov), 64'd1);
        chk(tag, 64'(last_out), 64'(want));
    endtask

    function automatic logic [47:0] bp_sig(input int k);
        return (48'd1 << 46) | (48'(k + 1) << 30);
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, tries, k, r, t;
        logic [63:0] rnd64;
        logic [47:0] sg;
        logic [9:0]  ev;
        logic [2:0]  fl;

        apply_reset();

        directed("one",      1'b0, 10'd127, 48'd1 << 46, 3'b000, {3'b000, 32'h3F800000});
        directed("tie_odd",  1'b0, 10'd127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22),
                 3'b000, {3'b001, 32'h3F800002});
        directed("ovf",      1'b0, 10'd254, 48'hFFFF_FFFF_FFFF, 3'b000, {3'b101, 32'h7F800000});
        directed("subnorm",  1'b0, 10'd1, 48'd1 << 45, 3'b000, {3'b000, 32'h00400000});
        directed("sub2norm", 1'b0, 10'd0, (48'd1 << 47) - 48'd1, 3'b000, {3'b011, 32'h00800000});
        directed("exp_min",  1'b0, 10'h200, 48'd1 << 46, 3'b000, {3'b011, 32'h00000000});
        directed("exp_max",  1'b1, 10'h1FF, 48'd1, 3'b000, {3'b101, 32'hFF800000});
        directed("nan",      1'b1, 10'd5, 48'd7, 3'b111, {3'b000, 32'h7FC00000});
        directed("inf",      1'b1, 10'd5, 48'd7, 3'b011, {3'b000, 32'hFF800000});
        directed("zero",     1'b1, 10'd127, 48'd1 << 46, 3'b001, {3'b000, 32'h80000000});
        directed("sig0",     1'b0, 10'd127, 48'd0, 3'b000, {3'b000, 32'h00000000});

        // Back-pressure: downstream stalled for three cycles.
        base = n_deliv;
        step(1'b1, 1'b0, 10'd127, bp_sig(0), 3'b000, 1'b0);
        chk("bp_acc0", 64'(last_acc), 64'd1);
        step(1'b1, 1'b0, 10'd127, bp_sig(1), 3'b000, 1'b0);
        chk("bp_acc1", 64'(last_acc), 64'd1);
        step(1'b1, 1'b0, 10'd127, bp_sig(2), 3'b000, 1'b0);
        chk("bp_in_ready_low", 64'(last_ir), 64'd0);
        for (int b = 2; b < 4; b++) begin
            tries = 0;
            last_acc = 1'b0;
            while (!last_acc && tries < 10) begin
                step(1'b1, 1'b0, 10'd127, bp_sig(b), 3'b000, 1'b1);
                tries++;
            end
            chk("bp_accept_late", 64'(last_acc), 64'd1);
        end
        tries = 0;
        while (exp_q.size() != 0 && tries < 20) begin
            idle(1'b1);
            tries++;
        end
        chk("bp_delivered", 64'(n_deliv - base), 64'd4);

        // Reset with two beats in flight: neither may come out afterwards.
        step(1'b1, 1'b0, 10'd127, bp_sig(5), 3'b000, 1'b0);
        step(1'b1, 1'b0, 10'd127, bp_sig(6), 3'b000, 1'b0);
        apply_reset();
        base = n_deliv;
        for (int c = 0; c < 6; c++) idle(1'b1);
        chk("rst_flush_no_emit", 64'(n_deliv - base), 64'd0);
        chk("rst_flush_idle", 64'(last_ov), 64'd0);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 15));
            fl = 3'b000;
            if (r == 0) fl = 3'b100;
            if (r == 1) fl = 3'b010;
            if (r == 2) fl = 3'b001;
            rnd64 = {$urandom(), $urandom()};
            sg = rnd64[47:0];
            if ($urandom_range(0, 1) == 1) sg = sg >> $urandom_range(0, 47);
            if (r == 3) sg = 48'd0;
            if ($urandom_range(0, 3) == 0) begin
                rnd64 = {32'd0, $urandom()};
                ev = rnd64[9:0];
            end else begin
                t  = int'($urandom_range(0, 340)) - 40;
                ev = 10'(t);
            end
            k = int'($urandom_range(0, 3));
            step(k != 0, 1'($urandom_range(0, 1)), ev, sg, fl, $urandom_range(0, 9) < 7);
        end
        tries = 0;
        while (exp_q.size() != 0 && tries < 20) begin
            idle(1'b1);
            tries++;
        end
        chk("final_drain", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
